alu_issue_stage: RTL
====================

# alu_issue_stage

Pipeline stage directly upstream of the 32-bit ALU (`yAlu`). It takes decoded instruction fields, sign-extends the immediate and selects operand `b`. It decodes the 3-bit ALU operation from the main-control class and `funct`, then registers `a`/`b`/`op` toward the ALU over a valid/ready handshake. A one-entry skid buffer keeps `in_ready` registered, so upstream stalls never combinationally depend on downstream.

## Interface
Parameters:
- `W`, 32: datapath width; operands `a`/`b`.
- `IMM_W`, 16: immediate width; sign-extended to `W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all held entries.
- `in_valid`  in  1  upstream offers an entry.
- `in_ready`  out  1  stage can accept; registered.
- `rs_val`  in  W  register operand A.
- `rt_val`  in  W  register operand B.
- `imm`  in  IMM_W  raw immediate.
- `alu_src`  in  1  1: `b` = sign-extended `imm`; 0: `b` = `rt_val`.
- `alu_class`  in  2  00 add, 01 sub, 10 decode `funct`, 11 slt.
- `funct`  in  6  R-type function field.
- `out_valid`  out  1  entry presented to ALU.
- `out_ready`  in  1  ALU/EX stage accepts.
- `a`  out  W  ALU operand A.
- `b`  out  W  ALU operand B.
- `op`  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- `illegal`  out  1  entry carries an unsupported `funct`; `op` forced to 010.

## Operation
- Decode is combinational on the input side:
  - class 00 → 010; class 01 → 110; class 11 → 111.
  - class 10: `funct` 0x20→010, 0x22→110, 0x24→000, 0x25→001, 0x2A→111.
  - Any other `funct` → op 010, `illegal`=1.
- Sign extension: `b_imm = {{(W-IMM_W){imm[IMM_W-1]}}, imm}`.
- Storage:
  - Output register (`out_*`) plus one skid entry; each holds {a, b, op, illegal}.
- States, encoded by the two valid bits:
  - EMPTY: out invalid, skid empty.
  - ONE: out valid, skid empty.
  - FULL: out valid, skid valid.
- `in_ready` = (state != FULL), registered.
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- Transitions:
  - EMPTY + accept → ONE; new entry goes to the output register.
  - ONE + accept & !drain → FULL; new entry goes to skid.
  - ONE + accept & drain → ONE; new entry goes to the output register.
  - ONE + drain & !accept → EMPTY.
  - FULL + drain → ONE; skid moves to the output register and skid clears. No accept is possible in FULL.
  - Otherwise the state holds.
- Output stability: while `out_valid & !out_ready`, `a`/`b`/`op`/`illegal` hold stable.
- `flush` has priority over accept and drain: next state EMPTY, `in_ready`=1. The entry offered in the flush cycle is dropped.
- Order is strictly FIFO; no entry is duplicated or lost except by flush.

## Timing
- Reset (async assert, sync release), all outputs: `out_valid`=0, `in_ready`=1, `a`=0, `b`=0, `op`=000, `illegal`=0.
- Latency: accept in cycle N → `out_valid` in cycle N+1 with that entry.
- Throughput: 1 entry/cycle while `out_ready`=1.
- `in_ready` falls one cycle after the accept that fills skid. It rises the cycle after the drain that empties skid.
- Reset mid-operation clears all entries immediately; no partial entry survives.
- `out_ready` asserted with `out_valid`=0 has no effect.

## Structure
- Shared package `alu_pkg`:
  - op constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`.
  - class constants and `funct` codes.
  - entry struct {a, b, op, illegal}.
- One sub-module: `alu_ctrl_dec`, combinational (`alu_class`, `funct` → `op`, `illegal`), reused by later EX-stage checks.
- Skid logic lives in the top module.

## Test plan
- Reset: hold `rst_n`=0 → `out_valid`=0, `in_ready`=1, `op`=000; release and hold with no input → no change.
- R-type or: `rs_val`=0x0000_00F0, `rt_val`=0x0000_000F, class 10, `funct` 0x25, `out_ready`=1 → next cycle `a`=0xF0, `b`=0x0F, `op`=001, `illegal`=0.
- Immediate slt: `alu_src`=1, `imm`=0xFFFE, class 11 → `b`=0xFFFF_FFFE, `op`=111. Feed `b` and `a`=5 to `yAlu` → `z`=0.
- Backpressure: `out_ready`=0, offer entries E1, E2, E3 on consecutive cycles.
  - E1 and E2 accepted; `in_ready`=0 from the cycle after E2 is accepted; E3 held upstream.
  - Raise `out_ready` → outputs E1, E2, E3 in order, with no gaps after the restart.
- Illegal `funct` 0x27 → `op`=010, `illegal`=1; next entry class 01 → `op`=110, `illegal`=0.
- Flush while FULL with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1; the flushed entries and the offered entry never appear at the output.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op/class/funct constants and issue entry type
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] CLS_ADD   = 2'b00;
    localparam logic [1:0] CLS_SUB   = 2'b01;
    localparam logic [1:0] CLS_FUNCT = 2'b10;
    localparam logic [1:0] CLS_SLT   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Encoding mirrors the {skid valid, out valid} bit pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } issue_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       op;
        logic             illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational ALU control decode from class and funct
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [5:0] funct,
    output logic [2:0] op,
    output logic       illegal
);

    always_comb begin
        op      = ALU_ADD;
        illegal = 1'b0;
        case (alu_class)
            CLS_ADD: op = ALU_ADD;
            CLS_SUB: op = ALU_SUB;
            CLS_SLT: op = ALU_SLT;
            default: begin
                case (funct)
                    FN_ADD:  op = ALU_ADD;
                    FN_SUB:  op = ALU_SUB;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_SLT:  op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand select, op decode and skid-buffered issue toward the ALU
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     rs_val,
    input  logic [W-1:0]     rt_val,
    input  logic [IMM_W-1:0] imm,
    input  logic             alu_src,
    input  logic [1:0]       alu_class,
    input  logic [5:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [2:0]       op,
    output logic             illegal
);

    logic [2:0]   dec_op;
    logic         dec_illegal;
    logic [W-1:0] b_imm;
    alu_entry_t   in_entry;
    alu_entry_t   out_q;
    alu_entry_t   skid_q;

    issue_state_e state_q;
    issue_state_e state_d;
    logic         in_ready_q;
    logic         accept;
    logic         drain;
    logic         load_out;
    logic         skid_to_out;
    logic         load_skid;

    alu_ctrl_dec u_dec (
        .alu_class (alu_class),
        .funct     (funct),
        .op        (dec_op),
        .illegal   (dec_illegal)
    );

    assign b_imm = {{(W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        in_entry.a       = rs_val;
        in_entry.b       = alu_src ? b_imm : rt_val;
        in_entry.op      = dec_op;
        in_entry.illegal = dec_illegal;
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        skid_to_out = 1'b0;
        load_skid   = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d  = ST_ONE;
                        load_out = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can move the state.
                    if (drain) begin
                        state_d     = ST_ONE;
                        skid_to_out = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= in_entry;
            end else if (skid_to_out) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign a       = out_q.a;
    assign b       = out_q.b;
    assign op      = out_q.op;
    assign illegal = out_q.illegal;

endmodule
